// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and parameter checks for counter_unit
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    // Minimum number of bits that can hold the values 0 .. m-1.
    function automatic int unsigned bits_for_modulus(input longint unsigned m);
        int unsigned b;
        b = $clog2(m);
        return (b == 0) ? 1 : b;
    endfunction

    function automatic bit params_legal(
        input int unsigned     width,
        input longint unsigned modulus,
        input longint unsigned reset_value
    );
        if (width < 1 || width > 32)                   return 1'b0;
        if (modulus < 2)                               return 1'b0;
        if (modulus > (64'd1 << width))                return 1'b0;
        if (reset_value >= modulus)                    return 1'b0;
        if (bits_for_modulus(modulus) > width)         return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/counter_unit.sv
// rtl/counter_unit.sv - free-running modulo/saturating up-counter with terminal-count strobe
module counter_unit
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH       = DEFAULT_WIDTH,
    parameter longint unsigned MODULUS     = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VALUE = 64'd0,
    parameter bit              SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (!params_legal(WIDTH, MODULUS, RESET_VALUE)) begin : g_bad_params
        $error("counter_unit: illegal WIDTH/MODULUS/RESET_VALUE combination");
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] INIT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_next;

    // With MODULUS == 2**WIDTH the wrap branch coincides with natural overflow.
    always_comb begin
        count_next = '0;
        if (count < LAST) begin
            count_next = count + WIDTH'(1);
        end else if (SATURATE) begin
            count_next = count;
        end else begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= INIT;
        end else begin
            count <= count_next;
        end
    end

    assign tc = reset && (count == LAST);

endmodule

// File: tb/tb_counter_unit.sv
// tb/tb_counter_unit.sv - scoreboard bench for counter_unit (wrap, mod-10, saturate)
module tb_counter_unit;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] count_a, count_b, count_c;
    logic       tc_a, tc_b, tc_c;

    always #5 clk = ~clk;

    counter_unit #(.WIDTH(4)) dut_wrap (
        .clk(clk), .reset(reset), .count(count_a), .tc(tc_a)
    );
    counter_unit #(.WIDTH(4), .MODULUS(10)) dut_mod10 (
        .clk(clk), .reset(reset), .count(count_b), .tc(tc_b)
    );
    counter_unit #(.WIDTH(4), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .count(count_c), .tc(tc_c)
    );

    typedef struct packed {
        logic [3:0] c0, c1, c2;
        logic       t0, t1, t2;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;

    int mod_of[NDUT] = '{16, 10, 16};
    bit sat_of[NDUT] = '{1'b0, 1'b0, 1'b1};
    int model_c[NDUT];
    bit started = 1'b0;
    bit rst_drv = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model over one rising edge, then drive the next reset level.
    task automatic step(input bit r);
        exp_t e;
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (!rst_drv)
                model_c[k] = 0;
            else if (sat_of[k])
                model_c[k] = (model_c[k] + 1 > mod_of[k] - 1) ? mod_of[k] - 1 : model_c[k] + 1;
            else
                model_c[k] = (model_c[k] + 1) % mod_of[k];
        end
        if (!rst_drv) started = 1'b1;
        #2;
        reset = r;
        rst_drv = r;
        if (started) begin
            e.c0 = 4'(model_c[0]);
            e.c1 = 4'(model_c[1]);
            e.c2 = 4'(model_c[2]);
            e.t0 = r && (model_c[0] == mod_of[0] - 1);
            e.t1 = r && (model_c[1] == mod_of[1] - 1);
            e.t2 = r && (model_c[2] == mod_of[2] - 1);
            exp_q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wrap_count",  int'(count_a), int'(e.c0));
                check("wrap_tc",     int'(tc_a),    int'(e.t0));
                check("mod10_count", int'(count_b), int'(e.c1));
                check("mod10_tc",    int'(tc_b),    int'(e.t1));
                check("sat_count",   int'(count_c), int'(e.c2));
                check("sat_tc",      int'(tc_c),    int'(e.t2));
            end
        end
    end

    initial begin : stimulus
        int budget;
        repeat (10) step(1'b0);
        repeat (25) step(1'b1);
        repeat (11) step(1'b0);
        repeat (11) step(1'b1);
        repeat (400) step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1);
        repeat (3) step(1'b1);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/counter_unit.md
# counter_unit

Free-running, parameterised binary up-counter used as the timebase/divider for the sound-generation datapath. It advances once per rising clock edge while out of reset and wraps at a configurable modulus. It emits a one-cycle terminal-count strobe so downstream blocks (tone dividers, sequencers) can cascade without decoding `count` themselves.

## Interface
Parameters:
- `WIDTH`, 4: bit width of `count`; legal range 1–32.
- `MODULUS`, 2**WIDTH: count sequence length; `count` runs 0 … MODULUS-1. Legal range 2 … 2**WIDTH; elaboration fails on an illegal value.
- `RESET_VALUE`, 0: value loaded by reset; must be < MODULUS.
- `SATURATE`, 0: 0 means wrap to 0 after MODULUS-1; 1 means hold at MODULUS-1.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: one clock; reset is synchronous and active-low. Low = reset asserted.
- `count` output WIDTH: current counter value, registered.
- `tc` output 1: terminal count; high while `count` == MODULUS-1 and `reset` is high.

## Operation
- Reset: at a rising edge with `reset`=0, `count` <= RESET_VALUE. Reset has priority over counting.
- Count: at a rising edge with `reset`=1:
  - if `count` < MODULUS-1, `count` <= `count`+1;
  - otherwise `count` <= 0 when SATURATE=0, or holds when SATURATE=1.
- Arithmetic is unsigned, WIDTH bits. With MODULUS = 2**WIDTH, the wrap is the natural WIDTH-bit overflow (4-bit: 15 → 0).
- `tc` is combinational from registered `count` and `reset`; it is 0 whenever `reset`=0.
- No enable and no load input. The counter runs every cycle out of reset.
- `count` is X until the first rising edge that samples `reset`=0. The system must assert reset for at least one edge.

## Timing
- Latency: `count` changes only after a rising edge. The first edge sampling `reset`=1 after reset produces RESET_VALUE+1.
- Reset assertion mid-count takes effect at the next rising edge. `count` is RESET_VALUE in the following cycle, with no partial states.
- Reset deassertion: counting begins at the first edge sampling `reset`=1; no extra idle cycle.
- `tc`, SATURATE=0: high for exactly one cycle every MODULUS cycles.
- `tc`, SATURATE=1: stays high once MODULUS-1 is reached, until reset.
- Stimulus must change `reset` away from the active clock edge. Behaviour with `reset` changing exactly at the edge is simulator-order dependent and is not specified.

## Structure
- A shared package `counter_pkg` holds:
  - the default width constant (4);
  - a function computing the bit width needed for a given modulus;
  - the legal-parameter check used by the elaboration assertions.
- Implementation: one `always @(posedge clk)` register process plus combinational next-state and `tc` logic. No sub-modules.
- An optional companion `counter_unit_chain` cascades instances through `tc` for wide dividers. It is out of scope for this block.

## Test plan
- Reset hold: `reset`=0 for 10 cycles, WIDTH=4 → `count`=0 and `tc`=0 throughout.
- Release and count: `reset` low 10 cycles then high 11 cycles → `count` reads 1,2,…,11 on successive edges.
- Wrap: WIDTH=4 defaults, run 20 cycles from reset → sequence 1…15, 0, 1…4; `tc`=1 only while `count`=15.
- Mid-count reset: count to 11, drive `reset`=0 for 11 cycles, then `reset`=1 for 11 cycles → `count`=0 one edge after assertion and stays 0; then counts 1…11 again.
- Non-power-of-two modulus: MODULUS=10, WIDTH=4 → sequence 0…9, 0, …; `tc` pulses every 10 cycles.
- Saturate: SATURATE=1, WIDTH=4, 20 cycles → `count` holds at 15 and `tc` stays 1 until `reset`=0 returns `count` to 0.
